dma_copy32: RTL and testbench

DMA_COPY32 -- requirements
Module: dma_copy32

---
 rtl/dma_pkg.sv | 33 +++
 rtl/dma_cfg_regs.sv | 58 +++++
 rtl/dma_copy32.sv | 148 ++++++++++++++
 tb/tb_dma_copy32.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the dma_copy32 word-copy engine.
package dma_pkg;

    // Copy engine states; read and write halves mirror each other.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RD_REQ     = 3'd1,
        ST_RD_WAIT_LO = 3'd2,
        ST_RD_WAIT_HI = 3'd3,
        ST_WR_REQ     = 3'd4,
        ST_WR_WAIT_LO = 3'd5,
        ST_WR_WAIT_HI = 3'd6,
        ST_DONE       = 3'd7
    } dma_state_e;

    // Configuration targets selected by cfg_sel.
    typedef enum logic [1:0] {
        CFG_SRC       = 2'd0,
        CFG_DST       = 2'd1,
        CFG_LEN_START = 2'd2,
        CFG_CLEAR     = 2'd3
    } cfg_sel_e;

    // status_out flag positions; remaining count sits in the low bits.
    localparam int STAT_BUSY = 31;
    localparam int STAT_DONE = 30;
    localparam int STAT_ERR  = 29;

    // Lowest legal source / destination addresses.
    localparam logic [31:0] DEF_RD_BASE = 32'h0400_0000;
    localparam logic [31:0] DEF_WR_BASE = 32'h0400_2000;

endpackage

// File: rtl/dma_cfg_regs.sv
// Configuration registers: SRC/DST (word aligned), remaining word count,
// and the write block that freezes configuration while a copy runs.
module dma_cfg_regs
    import dma_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             cfg_wr,
    input  logic [1:0]       cfg_sel,
    input  logic [31:0]      cfg_in,
    input  logic             busy,
    input  logic             dec,
    output logic [31:0]      src,
    output logic [31:0]      dst,
    output logic [LEN_W-1:0] remaining,
    output logic             start,
    output logic             clear
);

    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             wr_ok;

    // Decode accepted writes and compute register next values.
    always_comb begin
        wr_ok = cfg_wr && !busy;
        start = wr_ok && (cfg_sel == CFG_LEN_START);
        clear = wr_ok && (cfg_sel == CFG_CLEAR);
        src_d = src_q;
        dst_d = dst_q;
        rem_d = rem_q;
        if (wr_ok && cfg_sel == CFG_SRC) src_d = {cfg_in[31:2], 2'b00};
        if (wr_ok && cfg_sel == CFG_DST) dst_d = {cfg_in[31:2], 2'b00};
        if (start)    rem_d = cfg_in[LEN_W-1:0];
        else if (dec) rem_d = rem_q - LEN_W'(1);
    end

    // Register state; reset clears all configuration.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            src_q <= '0;
            dst_q <= '0;
            rem_q <= '0;
        end else begin
            src_q <= src_d;
            dst_q <= dst_d;
            rem_q <= rem_d;
        end
    end

    assign src       = src_q;
    assign dst       = dst_q;
    assign remaining = rem_q;

endmodule

// File: rtl/dma_copy32.sv
// Single-outstanding-word memory copy engine with a req/data_rdy handshake
// bus. Each word is read from SRC+4i and written to DST+4i.
module dma_copy32
    import dma_pkg::*;
#(
    parameter int          LEN_W   = 8,
    parameter logic [31:0] RD_BASE = DEF_RD_BASE,
    parameter logic [31:0] WR_BASE = DEF_WR_BASE
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        cfg_wr,
    input  logic [1:0]  cfg_sel,
    input  logic [31:0] cfg_in,
    output logic [31:0] status_out,
    output logic        req_rd,
    output logic        req_wr,
    output logic [31:0] addr_rd,
    output logic [31:0] addr_wr,
    output logic [31:0] data_wr,
    input  logic [31:0] data_rd,
    input  logic        data_rdy,
    output logic        int_done
);

    dma_state_e       state_q, state_d;
    logic [31:0]      rd_addr_q, rd_addr_d;
    logic [31:0]      wr_addr_q, wr_addr_d;
    logic [31:0]      data_q, data_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             int_q, int_d;

    logic [31:0]      src, dst;
    logic [LEN_W-1:0] remaining;
    logic             start, clear, busy;
    logic             cfg_bad, len_zero;
    logic             rd_cap, wr_fin, enter_done;

    dma_cfg_regs #(.LEN_W(LEN_W)) u_cfg (
        .clk       (clk),
        .arst      (arst),
        .cfg_wr    (cfg_wr),
        .cfg_sel   (cfg_sel),
        .cfg_in    (cfg_in),
        .busy      (busy),
        .dec       (wr_fin),
        .src       (src),
        .dst       (dst),
        .remaining (remaining),
        .start     (start),
        .clear     (clear)
    );

    // Length is taken straight from the start write since the count
    // register only loads on that same edge.
    assign cfg_bad  = (src < RD_BASE) || (dst < WR_BASE);
    assign len_zero = (cfg_in[LEN_W-1:0] == '0);

    // State register.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state: each access waits for data_rdy to drop then rise again.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (start) state_d = (cfg_bad || len_zero) ? ST_DONE : ST_RD_REQ;
            ST_RD_REQ:     if (data_rdy)  state_d = ST_RD_WAIT_LO;
            ST_RD_WAIT_LO: if (!data_rdy) state_d = ST_RD_WAIT_HI;
            ST_RD_WAIT_HI: if (data_rdy)  state_d = ST_WR_REQ;
            ST_WR_REQ:     if (data_rdy)  state_d = ST_WR_WAIT_LO;
            ST_WR_WAIT_LO: if (!data_rdy) state_d = ST_WR_WAIT_HI;
            ST_WR_WAIT_HI: if (data_rdy)  state_d = (remaining > LEN_W'(1)) ? ST_RD_REQ : ST_DONE;
            ST_DONE:       state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: bus requests and datapath strobes decoded from state.
    always_comb begin
        busy       = (state_q != ST_IDLE);
        req_rd     = (state_q == ST_RD_REQ);
        req_wr     = (state_q == ST_WR_REQ);
        rd_cap     = (state_q == ST_RD_WAIT_HI) && data_rdy;
        wr_fin     = (state_q == ST_WR_WAIT_HI) && data_rdy;
        enter_done = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    // Datapath next values: address walk, read data capture, flags.
    always_comb begin
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        data_d    = data_q;
        done_d    = done_q;
        err_d     = err_q;
        int_d     = int_q;
        if (start) begin
            rd_addr_d = src;
            wr_addr_d = dst;
            done_d    = 1'b0;
            int_d     = 1'b0;
            err_d     = cfg_bad;
        end
        if (clear) begin
            done_d = 1'b0;
            err_d  = 1'b0;
            int_d  = 1'b0;
        end
        if (rd_cap) data_d = data_rd;
        if (wr_fin) begin
            rd_addr_d = rd_addr_q + 32'd4;
            wr_addr_d = wr_addr_q + 32'd4;
        end
        if (enter_done) begin
            done_d = 1'b1;
            int_d  = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            int_q     <= 1'b0;
        end else begin
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            data_q    <= data_d;
            done_q    <= done_d;
            err_q     <= err_d;
            int_q     <= int_d;
        end
    end

    assign addr_rd    = rd_addr_q;
    assign addr_wr    = wr_addr_q;
    assign data_wr    = data_q;
    assign int_done   = int_q;
    assign status_out = {busy, done_q, err_q, {(29-LEN_W){1'b0}}, remaining};

endmodule

// File: tb/tb_dma_copy32.sv
// Self-checking bench for dma_copy32 with a memory responder model and a
// scoreboard of expected (read addr, write addr, data) per copied word.
module tb_dma_copy32;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        cfg_wr = 1'b0;
    logic [1:0]  cfg_sel = 2'd0;
    logic [31:0] cfg_in = 32'd0;
    logic [31:0] status_out, addr_rd, addr_wr, data_wr, data_rd;
    logic        req_rd, req_wr, data_rdy, int_done;

    dma_copy32 dut (
        .clk(clk), .arst(arst), .cfg_wr(cfg_wr), .cfg_sel(cfg_sel), .cfg_in(cfg_in),
        .status_out(status_out), .req_rd(req_rd), .req_wr(req_wr),
        .addr_rd(addr_rd), .addr_wr(addr_wr), .data_wr(data_wr),
        .data_rd(data_rd), .data_rdy(data_rdy), .int_done(int_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ra;
        logic [31:0] wa;
        logic [31:0] d;
    } xfer_t;

    xfer_t exp_q[$];
    xfer_t obs_q[$];

    int checks = 0;
    int passes = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int viol   = 0;
    int rsp_wait = 1;
    int rsp_cnt;
    logic [31:0] last_ra;

    function automatic logic [31:0] src_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    // Responder: accepts a request while data_rdy is high, then holds
    // data_rdy low for rsp_wait cycles before raising it again.
    always @(posedge clk or posedge arst) begin
        if (arst) begin
            data_rdy <= 1'b1;
            rsp_cnt  <= 0;
            data_rd  <= 32'd0;
        end else begin
            if (req_rd && req_wr) viol <= viol + 1;
            if (rsp_cnt != 0) begin
                rsp_cnt <= rsp_cnt - 1;
                if (rsp_cnt == 1) data_rdy <= 1'b1;
            end else if (data_rdy && req_rd) begin
                data_rdy <= 1'b0;
                rsp_cnt  <= rsp_wait;
                data_rd  <= src_word(addr_rd);
                last_ra  <= addr_rd;
                rd_cnt   <= rd_cnt + 1;
            end else if (data_rdy && req_wr) begin
                data_rdy <= 1'b0;
                rsp_cnt  <= rsp_wait;
                wr_cnt   <= wr_cnt + 1;
                obs_q.push_back('{last_ra, addr_wr, data_wr});
            end
        end
    end

    task automatic cfg(input logic [1:0] s, input logic [31:0] v);
        @(negedge clk);
        cfg_wr = 1'b1; cfg_sel = s; cfg_in = v;
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] s, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back('{s + 32'(4*i), d + 32'(4*i), src_word(s + 32'(4*i))});
    endtask

    task automatic wait_int(input int budget, output int n);
        n = 0;
        while (int_done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_rd, req_wr, int_done, status_out, addr_rd, addr_wr, data_wr} !== '0)
            $display("FAIL reset_outputs: got st=%h rd=%b wr=%b int=%b, want all 0",
                     status_out, req_rd, req_wr, int_done);
        else passes++;
        arst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (rd_cnt + wr_cnt !== 0 || status_out !== 32'd0)
            $display("FAIL reset_idle: got bus=%0d st=%h, want 0/0", rd_cnt + wr_cnt, status_out);
        else passes++;
    endtask

    task automatic test_copy;
        int n, r0;
        xfer_t e, o;
        r0 = rd_cnt;
        cfg(0, 32'h0400_0000);
        cfg(1, 32'h0400_2000);
        push_exp(32'h0400_0000, 32'h0400_2000, 4);
        cfg(2, 32'd4);
        wait_int(100, n);
        checks++;
        if (n !== 24) $display("FAIL copy_latency: got %0d cycles, want 24", n);
        else passes++;
        @(negedge clk);
        checks++;
        if (status_out !== 32'h4000_0000 || int_done !== 1'b1)
            $display("FAIL copy_status: got st=%h int=%b, want 40000000/1", status_out, int_done);
        else passes++;
        checks++;
        if (rd_cnt - r0 !== 4) $display("FAIL copy_reads: got %0d, want 4", rd_cnt - r0);
        else passes++;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) $display("FAIL copy_word: missing write for ra=%h", e.ra);
            else begin
                o = obs_q.pop_front();
                if ({o.ra, o.wa, o.d} !== {e.ra, e.wa, e.d})
                    $display("FAIL copy_word: got %h->%h d=%h, want %h->%h d=%h",
                             o.ra, o.wa, o.d, e.ra, e.wa, e.d);
                else passes++;
            end
        end
        checks++;
        if (obs_q.size() != 0) $display("FAIL copy_extra: got %0d extra writes, want 0", obs_q.size());
        else passes++;
    endtask

    task automatic test_clear;
        cfg(3, 32'd0);
        checks++;
        if (int_done !== 1'b0 || status_out !== 32'd0)
            $display("FAIL clear: got st=%h int=%b, want 0/0", status_out, int_done);
        else passes++;
    endtask

    task automatic test_len0;
        int b0;
        b0 = rd_cnt + wr_cnt;
        cfg(2, 32'd0);
        checks++;
        if (int_done !== 1'b1) $display("FAIL len0_int: got %b, want 1", int_done);
        else passes++;
        repeat (3) @(negedge clk);
        checks++;
        if (status_out !== 32'h4000_0000 || rd_cnt + wr_cnt !== b0)
            $display("FAIL len0_status: got st=%h bus=%0d, want 40000000/0", status_out, rd_cnt + wr_cnt - b0);
        else passes++;
        cfg(3, 32'd0);
    endtask

    task automatic test_error;
        int b0;
        b0 = rd_cnt + wr_cnt;
        cfg(0, 32'h0000_1000);
        cfg(1, 32'h0400_2000);
        cfg(2, 32'd4);
        checks++;
        if (int_done !== 1'b1) $display("FAIL err_src_int: got %b, want 1", int_done);
        else passes++;
        repeat (10) @(negedge clk);
        checks++;
        if (status_out[29] !== 1'b1 || rd_cnt + wr_cnt !== b0)
            $display("FAIL err_src: got err=%b bus=%0d, want 1/0", status_out[29], rd_cnt + wr_cnt - b0);
        else passes++;
        cfg(3, 32'd0);
        cfg(0, 32'h0400_0000);
        cfg(1, 32'h0400_1FFC);
        cfg(2, 32'd2);
        repeat (5) @(negedge clk);
        checks++;
        if (status_out[29] !== 1'b1 || int_done !== 1'b1 || rd_cnt + wr_cnt !== b0)
            $display("FAIL err_dst: got err=%b int=%b bus=%0d, want 1/1/0",
                     status_out[29], int_done, rd_cnt + wr_cnt - b0);
        else passes++;
        cfg(3, 32'd0);
    endtask

    task automatic test_slow;
        int n, r0, w0;
        xfer_t e, o;
        r0 = rd_cnt; w0 = wr_cnt;
        rsp_wait = 5;
        cfg(0, 32'h0400_0040);
        cfg(1, 32'h0400_2040);
        push_exp(32'h0400_0040, 32'h0400_2040, 2);
        cfg(2, 32'd2);
        wait_int(200, n);
        checks++;
        if (n !== 28) $display("FAIL slow_latency: got %0d cycles, want 28", n);
        else passes++;
        @(negedge clk);
        rsp_wait = 1;
        checks++;
        if (rd_cnt - r0 !== 2 || wr_cnt - w0 !== 2 || viol !== 0)
            $display("FAIL slow_accepts: got rd=%0d wr=%0d both=%0d, want 2/2/0", rd_cnt - r0, wr_cnt - w0, viol);
        else passes++;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) $display("FAIL slow_word: missing write for ra=%h", e.ra);
            else begin
                o = obs_q.pop_front();
                if ({o.ra, o.wa, o.d} !== {e.ra, e.wa, e.d})
                    $display("FAIL slow_word: got %h->%h d=%h, want %h->%h d=%h",
                             o.ra, o.wa, o.d, e.ra, e.wa, e.d);
                else passes++;
            end
        end
    endtask

    task automatic test_busy_ignore;
        int n;
        xfer_t e, o;
        cfg(0, 32'h0400_0000);
        cfg(1, 32'h0400_2100);
        push_exp(32'h0400_0000, 32'h0400_2100, 4);
        cfg(2, 32'd4);
        cfg(0, 32'h0400_0100);
        cfg(2, 32'd9);
        wait_int(100, n);
        @(negedge clk);
        checks++;
        if (status_out !== 32'h4000_0000 || int_done !== 1'b1)
            $display("FAIL busy_status: got st=%h int=%b, want 40000000/1", status_out, int_done);
        else passes++;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) $display("FAIL busy_word: missing write for ra=%h", e.ra);
            else begin
                o = obs_q.pop_front();
                if ({o.ra, o.wa, o.d} !== {e.ra, e.wa, e.d})
                    $display("FAIL busy_word: got %h->%h d=%h, want %h->%h d=%h",
                             o.ra, o.wa, o.d, e.ra, e.wa, e.d);
                else passes++;
            end
        end
        checks++;
        if (obs_q.size() != 0) $display("FAIL busy_extra: got %0d extra writes, want 0", obs_q.size());
        else passes++;
    endtask

    task automatic test_wrap_align;
        int n;
        xfer_t e, o;
        cfg(0, 32'hFFFF_FFFB);
        cfg(1, 32'hFFFF_FFF2);
        push_exp(32'hFFFF_FFF8, 32'hFFFF_FFF0, 3);
        cfg(2, 32'd3);
        wait_int(100, n);
        @(negedge clk);
        checks++;
        if (status_out !== 32'h4000_0000) $display("FAIL wrap_status: got %h, want 40000000", status_out);
        else passes++;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) $display("FAIL wrap_word: missing write for ra=%h", e.ra);
            else begin
                o = obs_q.pop_front();
                if ({o.ra, o.wa, o.d} !== {e.ra, e.wa, e.d})
                    $display("FAIL wrap_word: got %h->%h d=%h, want %h->%h d=%h",
                             o.ra, o.wa, o.d, e.ra, e.wa, e.d);
                else passes++;
            end
        end
    endtask

    task automatic test_reset_mid;
        int n, r0, w0;
        w0 = wr_cnt;
        cfg(0, 32'h0400_0000);
        cfg(1, 32'h0400_2000);
        cfg(2, 32'd3);
        n = 0;
        while (wr_cnt != w0 + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (wr_cnt != w0 + 2) $display("FAIL rst_mid_reach: got %0d writes, want 2", wr_cnt - w0);
        else passes++;
        arst = 1'b1;
        #1;
        checks++;
        if ({req_rd, req_wr, int_done, status_out, addr_rd, addr_wr, data_wr} !== '0)
            $display("FAIL rst_mid_outputs: got st=%h aw=%h d=%h, want all 0", status_out, addr_wr, data_wr);
        else passes++;
        @(negedge clk);
        arst = 1'b0;
        r0 = rd_cnt; w0 = wr_cnt;
        repeat (20) @(negedge clk);
        checks++;
        if (rd_cnt !== r0 || wr_cnt !== w0 || status_out !== 32'd0 || int_done !== 1'b0)
            $display("FAIL rst_mid_idle: got rd=%0d wr=%0d st=%h, want 0/0/0",
                     rd_cnt - r0, wr_cnt - w0, status_out);
        else passes++;
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_copy();
        test_clear();
        test_len0();
        test_error();
        test_slow();
        test_busy_ignore();
        test_wrap_align();
        test_reset_mid();
        checks++;
        if (viol !== 0) $display("FAIL both_req: got %0d cycles with both requests, want 0", viol);
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
